serial_parity_nb: RTL and testbench

SERIAL_PARITY_NB -- requirements
Module: serial_parity_nb

---
 rtl/serial_parity_nb.sv | 99 +++++++++
 tb/tb_serial_parity_nb.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_nb.sv
// Bit-serial parity generator: loads a word, counts its ones one bit per enabled tick,
// stops as soon as the remaining bits are all zero, and reports the count and the parity bit.
module serial_parity_nb #(
    parameter int N  = 16,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    input  logic          start,
    input  logic [N-1:0]  din,
    input  logic          odd_sel,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count,
    output logic          par
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [N-1:0]  sreg_reg, sreg_next;
    logic [CW-1:0] count_reg, count_next;
    logic          mode_reg, mode_next;
    logic          par_reg, par_next;

    // Logical right shift by one with zero fill into the top bit.
    logic [N-1:0]  sreg_shr;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_shr
            if (gi == N - 1) begin : g_top
                assign sreg_shr[gi] = 1'b0;
            end else begin : g_body
                assign sreg_shr[gi] = sreg_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= IDLE;
            sreg_reg  <= '0;
            count_reg <= '0;
            mode_reg  <= 1'b0;
            par_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sreg_reg  <= sreg_next;
            count_reg <= count_next;
            mode_reg  <= mode_next;
            par_reg   <= par_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sreg_next  = sreg_reg;
        count_next = count_reg;
        mode_next  = mode_reg;
        par_next   = par_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = SHIFT;
                    sreg_next  = din;
                    mode_next  = odd_sel;
                    count_next = '0;
                    par_next   = 1'b0;
                end
            end
            SHIFT: begin
                // An all-zero remainder ends the scan early; no more ones can follow.
                if (en) begin
                    if (sreg_reg != '0) begin
                        count_next = count_reg + CW'(sreg_reg[0]);
                        sreg_next  = sreg_shr;
                    end else begin
                        state_next = DONE;
                        par_next   = count_reg[0] ^ mode_reg;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy  = (state_reg == SHIFT);
    assign done  = (state_reg == DONE);
    assign count = count_reg;
    assign par   = par_reg;

endmodule

// File: tb/tb_serial_parity_nb.sv
// Directed bench for serial_parity_nb: a word-level model predicts busy/done/count/par each
// cycle, and each scenario also checks hand-computed final values and enabled-cycle counts.
module tb_serial_parity_nb;

    logic        clk = 1'b0;
    logic        clr, en, start, odd_sel;
    logic [15:0] din;
    logic        busy, done, par;
    logic [4:0]  count;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    serial_parity_nb #(.N(16), .CW(5)) dut (
        .clk(clk), .clr(clr), .en(en), .start(start), .din(din), .odd_sel(odd_sel),
        .busy(busy), .done(done), .count(count), .par(par)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Model: 0 = idle, 1 = scanning, 2 = finished. Scan length comes straight from the
    // highest set bit of the latched word; the live count is the ones in the bits consumed so far.
    int          m_state = 0;
    logic [15:0] m_din   = '0;
    logic        m_odd   = 1'b0;
    int          m_en    = 0;

    function automatic int scan_len(input logic [15:0] v);
        int r;
        r = 1;
        for (int i = 0; i < 16; i++) if (v[i]) r = i + 2;
        return r;
    endfunction

    function automatic int low_ones(input logic [15:0] v, input int nb);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++) if (i < nb && v[i]) r++;
        return r;
    endfunction

    always @(posedge clk) begin
        if (clr) begin
            m_state = 0; m_din = '0; m_odd = 1'b0; m_en = 0;
        end else if (m_state != 1) begin
            if (start) begin
                m_state = 1; m_din = din; m_odd = odd_sel; m_en = 0;
            end
        end else if (en) begin
            m_en++;
            if (m_en == scan_len(m_din)) m_state = 2;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            int ec, ep;
            ec = (m_state == 0) ? 0 : (m_state == 1) ? low_ones(m_din, m_en) : $countones(m_din);
            ep = (m_state == 2) ? ($countones(m_din) % 2) ^ int'(m_odd) : 0;
            check("cyc busy", 32'(busy), 32'(m_state == 1));
            check("cyc done", 32'(done), 32'(m_state == 2));
            check("cyc count", 32'(count), 32'(ec));
            check("cyc par", 32'(par), 32'(ep));
        end
    end

    task automatic wait_done(input string nm, input int period, output int n);
        bit fin;
        fin = 1'b0;
        n = 0;
        for (int i = 0; i < 400 && !fin; i++) begin
            en = ((i % period) == 0);
            if (busy && en) n++;
            @(negedge clk);
            if (done) fin = 1'b1;
        end
        en = 1'b0;
        check({nm, " finished"}, 32'(fin), 32'd1);
    endtask

    task automatic run(input string nm, input logic [15:0] d, input logic o, input int period,
                       input int exp_n, input int exp_cnt, input int exp_par);
        int n;
        @(negedge clk);
        din = d; odd_sel = o; start = 1'b1; en = 1'b0;
        @(negedge clk);
        start = 1'b0; din = ~d; odd_sel = ~o;
        wait_done(nm, period, n);
        check({nm, " en cycles"}, 32'(n), 32'(exp_n));
        check({nm, " count"}, 32'(count), 32'(exp_cnt));
        check({nm, " par"}, 32'(par), 32'(exp_par));
        en = 1'b1;
        repeat (3) @(negedge clk);
        en = 1'b0;
        check({nm, " hold done"}, 32'(done), 32'd1);
        check({nm, " hold count"}, 32'(count), 32'(exp_cnt));
        $display("[TB] %s din=%h odd=%0d -> count=%0d par=%0d en_cycles=%0d", nm, d, o, count, par, n);
    endtask

    initial begin
        int n;
        clr = 1'b1; en = 1'b0; start = 1'b0; din = '0; odd_sel = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset count", 32'(count), 32'd0);
        check("reset par", 32'(par), 32'd0);
        chk_on = 1'b1;
        clr = 1'b0;
        @(negedge clk);

        run("zero",      16'h0000, 1'b0, 1, 1,  0,  0);
        run("ones",      16'hFFFF, 1'b0, 1, 17, 16, 0);
        run("seven_ev",  16'h0007, 1'b0, 1, 4,  3,  1);
        run("seven_od",  16'h0007, 1'b1, 1, 4,  3,  0);
        run("sparse_en", 16'h8001, 1'b1, 4, 17, 2,  1);

        // Abort mid-scan with start held across the clear.
        @(negedge clk);
        din = 16'hFFFF; odd_sel = 1'b0; start = 1'b1; en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort pre count", 32'(count), 32'd2);
        clr = 1'b1; start = 1'b1;
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort count", 32'(count), 32'd0);
        clr = 1'b0; start = 1'b0; en = 1'b0;
        @(negedge clk);
        check("abort idle", 32'(busy), 32'd0);
        $display("[TB] abort mid-scan -> busy=%0d done=%0d count=%0d", busy, done, count);
        run("restart",   16'h0007, 1'b0, 1, 4,  3,  1);

        // start during the scan is ignored; start in DONE reloads.
        @(negedge clk);
        din = 16'h0003; odd_sel = 1'b0; start = 1'b1; en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        din = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", 1, n);
        check("ignore count", 32'(count), 32'd2);
        check("ignore par", 32'(par), 32'd0);
        $display("[TB] start ignored in scan -> count=%0d par=%0d", count, par);
        din = 16'h0001; odd_sel = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("reload done", 32'(done), 32'd0);
        check("reload busy", 32'(busy), 32'd1);
        wait_done("reload", 1, n);
        check("reload count", 32'(count), 32'd1);
        check("reload par", 32'(par), 32'd1);
        $display("[TB] reload from done -> count=%0d par=%0d", count, par);

        @(negedge clk);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
